// File: rtl/conv_pkg.sv
// Shared definitions for the ML-KEM byte/bit conversion blocks.
//   Q, N_COEFFS   : ML-KEM modulus and polynomial length
//   bytes2bits_f  : flat bit position of bit j of byte i in the
//                   little-endian bit vector (bit 0 of byte 0 -> bit 0)
package conv_pkg;

  localparam int unsigned Q        = 3329;
  localparam int unsigned N_COEFFS = 256;

  function automatic int bytes2bits_f(input int byte_idx, input int bit_idx);
    return 8 * byte_idx + bit_idx;
  endfunction

endpackage

// File: rtl/bytes_to_bits_core.sv
// Combinational BytesToBits mapping, no clock and no state.
//   bytes_i : [N_BYTES-1:0][7:0] packed bytes, index 0 = first byte
//   bits_o  : [8*N_BYTES-1:0]    little-endian flat bit vector
module bytes_to_bits_core
  import conv_pkg::*;
#(
  parameter int N_BYTES = 384
) (
  input  logic [N_BYTES-1:0][7:0] bytes_i,
  output logic [8*N_BYTES-1:0]    bits_o
);

  for (genvar i = 0; i < N_BYTES; i++) begin : g_byte
    for (genvar j = 0; j < 8; j++) begin : g_bit
      localparam int BitIdx = bytes2bits_f(i, j);
      assign bits_o[BitIdx] = bytes_i[i][j];
    end
  end

endmodule

// File: rtl/bytes_to_bits.sv
// BytesToBits with one registered valid/ready stage.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   valid_i, ready_o  : upstream handshake, bytes_i carries the word
//   valid_o, ready_i  : downstream handshake, bits_o carries the result
// ready_o is purely a function of the output register and ready_i, so
// there is no combinational path from valid_i back to ready_o.
module bytes_to_bits
  import conv_pkg::*;
#(
  parameter int N_BYTES = 384
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [N_BYTES-1:0][7:0] bytes_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [8*N_BYTES-1:0]    bits_o
);

  localparam int W = 8 * N_BYTES;

  if (N_BYTES < 1) begin : g_param_chk
    $error("bytes_to_bits: N_BYTES must be >= 1");
  end

  logic         valid_q, valid_d;
  logic [W-1:0] bits_q, bits_d;
  logic [W-1:0] bits_map;

  bytes_to_bits_core #(
    .N_BYTES (N_BYTES)
  ) u_core (
    .bytes_i (bytes_i),
    .bits_o  (bits_map)
  );

  assign ready_o = !valid_q || ready_i;

  // The data register only loads on an accept, so bytes_i (even X) is
  // never sampled while valid_i is low, and a drain keeps the last word.
  always_comb begin
    valid_d = valid_q;
    bits_d  = bits_q;
    if (ready_o) begin
      valid_d = valid_i;
    end
    if (valid_i && ready_o) begin
      bits_d = bits_map;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
    end else begin
      valid_q <= valid_d;
      bits_q  <= bits_d;
    end
  end

  assign valid_o = valid_q;
  assign bits_o  = bits_q;

endmodule

// File: tb/tb_bytes_to_bits.sv
// Four instances (N_BYTES = 1, 2, 32, 384) share one stimulus stream; each
// takes the low bytes of a 384-byte word. A queue holds accepted words and a
// negedge monitor pops and compares whenever a word leaves the stage.
module tb_bytes_to_bits;

  localparam int NMAX = 384;
  localparam int WMAX = 8 * NMAX;
  localparam int HW   = 8 + 16 + 256 + WMAX;

  typedef logic [NMAX-1:0][7:0] word_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  valid_i = 1'b0;
  logic  ready_i = 1'b0;
  word_t bytes_i = '0;

  logic rdy1, rdy2, rdy32, rdy384;
  logic vo1, vo2, vo32, vo384;
  logic [7:0]      b1;
  logic [15:0]     b2;
  logic [255:0]    b32;
  logic [WMAX-1:0] b384;

  bytes_to_bits #(.N_BYTES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy1),
    .bytes_i(bytes_i[0:0]), .valid_o(vo1), .ready_i(ready_i), .bits_o(b1));
  bytes_to_bits #(.N_BYTES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy2),
    .bytes_i(bytes_i[1:0]), .valid_o(vo2), .ready_i(ready_i), .bits_o(b2));
  bytes_to_bits #(.N_BYTES(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy32),
    .bytes_i(bytes_i[31:0]), .valid_o(vo32), .ready_i(ready_i), .bits_o(b32));
  bytes_to_bits #(.N_BYTES(384)) dut384 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(rdy384),
    .bytes_i(bytes_i), .valid_o(vo384), .ready_i(ready_i), .bits_o(b384));

  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  int    pushed = 0;
  int    popped = 0;
  word_t sb[$];
  bit    mon_en = 1'b0;

  // Reference: the byte string read as a little-endian integer.
  function automatic logic [WMAX-1:0] model(input word_t w, input int n);
    logic [WMAX-1:0] e = '0;
    for (int i = n - 1; i >= 0; i--) e = (e << 8) | WMAX'(w[i]);
    return e;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < NMAX; i++) w[i] = 8'($urandom);
    return w;
  endfunction

  task automatic chk_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [WMAX-1:0] act,
                          input logic [WMAX-1:0] exp, input int n);
    int bad = -1;
    checks++;
    for (int k = 0; k < n; k++)
      if (bad < 0 && act[8*k +: 8] !== exp[8*k +: 8]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s byte=%0d act=%h exp=%h", name, bad, act[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  // Drive inputs at posedge+1, decide acceptance at negedge, record at posedge.
  task automatic step(input logic v, input logic r, input word_t w);
    logic acc;
    valid_i = v;
    ready_i = r;
    bytes_i = w;
    @(negedge clk);
    acc = valid_i && rdy384;
    @(posedge clk);
    if (acc) begin
      sb.push_back(w);
      pushed++;
    end
    #1;
  endtask

  // Monitor
  logic          hold_prev = 1'b0;
  logic [HW-1:0] hold_all;
  logic          ev;
  word_t         mw;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      ev = (sb.size() != 0);
      chk_vec("valid_o", 64'({vo1, vo2, vo32, vo384}), 64'({4{ev}}));
      chk_vec("ready_o", 64'({rdy1, rdy2, rdy32, rdy384}), 64'({4{!ev || ready_i}}));
      if (sb.size() > 1) begin
        errors++;
        $display("FAIL occupancy act=%0d exp<=1", sb.size());
      end
      if (hold_prev) begin
        checks++;
        if ({b1, b2, b32, b384} !== hold_all) begin
          errors++;
          $display("FAIL hold_stable act_lo=%h exp_lo=%h", b384[63:0], hold_all[63:0]);
        end
      end
      hold_prev = ev && !ready_i;
      hold_all  = {b1, b2, b32, b384};
      if (ev && ready_i) begin
        mw = sb.pop_front();
        popped++;
        chk_word("data_n1",   WMAX'(b1),  model(mw, 1),   1);
        chk_word("data_n2",   WMAX'(b2),  model(mw, 2),   2);
        chk_word("data_n32",  WMAX'(b32), model(mw, 32),  32);
        chk_word("data_n384", b384,       model(mw, 384), 384);
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w, a, b;
    int    cyc, start;
    bit    ok;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk_vec("reset_valid", 64'({vo1, vo2, vo32, vo384}), 64'd0);
    chk_vec("reset_bits_n2", 64'(b2), 64'd0);
    chk_word("reset_bits_n384", b384, '0, 384);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // N=2 directed: bytes {80,01}, no warm-up after reset
    w = '0;
    w[0] = 8'h01;
    w[1] = 8'h80;
    step(1'b1, 1'b1, w);
    chk_vec("dir_n2_valid", 64'(vo2), 64'd1);
    chk_vec("dir_n2_bits", 64'(b2), 64'h8001);

    // N=1 directed: A5
    w[0] = 8'hA5;
    step(1'b1, 1'b1, w);
    chk_vec("dir_n1_bits", 64'(b1), 64'hA5);

    // N=384 ramp
    for (int i = 0; i < NMAX; i++) w[i] = 8'(i);
    step(1'b1, 1'b1, w);
    ok = 1'b1;
    for (int i = 0; i < NMAX; i++) if (b384[8*i +: 8] !== 8'(i)) ok = 1'b0;
    chk_vec("dir_n384_ramp", 64'(ok), 64'd1);
    step(1'b0, 1'b1, rand_word());

    // Backpressure: A held 3 cycles while B is offered
    a = rand_word();
    b = rand_word();
    step(1'b1, 1'b0, a);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, b);
      chk_vec("bp_ready_low", 64'(rdy384), 64'd0);
      chk_word("bp_hold_a", b384, model(a, 384), 384);
    end
    step(1'b1, 1'b1, b);
    chk_word("bp_then_b", b384, model(b, 384), 384);

    // Drain with X on bytes_i: bits_o keeps B
    step(1'b0, 1'b1, 'x);
    step(1'b0, 1'b1, 'x);
    chk_vec("drain_valid", 64'(vo384), 64'd0);
    chk_word("drain_keeps_last", b384, model(b, 384), 384);

    // Streaming
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, rand_word());
      chk_vec("stream_valid", 64'(vo384), 64'd1);
    end
    step(1'b0, 1'b1, rand_word());

    // Asynchronous reset while a word is held
    step(1'b1, 1'b0, rand_word());
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_vec("midrst_valid", 64'({vo1, vo2, vo32, vo384}), 64'd0);
    chk_word("midrst_bits", b384, '0, 384);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    w = rand_word();
    step(1'b1, 1'b1, w);
    chk_vec("postrst_valid", 64'(vo384), 64'd1);
    chk_word("postrst_bits", b384, model(w, 384), 384);
    step(1'b0, 1'b1, rand_word());

    // Random traffic: 1000 words
    start = pushed;
    cyc = 0;
    while (pushed - start < 1000 && cyc < 20000) begin
      step(($urandom % 10) < 7, ($urandom % 10) < 7, rand_word());
      cyc++;
    end
    chk_vec("random_words_accepted", 64'(pushed - start), 64'd1000);
    repeat (3) step(1'b0, 1'b1, rand_word());
    chk_vec("sb_empty", 64'(sb.size()), 64'd0);
    chk_vec("pushed_vs_popped", 64'(popped), 64'(pushed - 1));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
